// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state, command and status encodings for the run-control responder
package run_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RUN, CAPTURE, REPORT, HALTED} state_t;
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_STEP = 2'd1;
  localparam logic [1:0] OP_HALT = 2'd2;
  localparam logic [1:0] ST_NOP_OK = 2'd0;
  localparam logic [1:0] ST_STEP_DONE = 2'd1;
  localparam logic [1:0] ST_BREAKPOINT = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;
endpackage

// File: rtl/run_ctrl.sv
// run_ctrl: gates the core clock-enable for host STEP/HALT/NOP commands and reports PC, cycles and stop status
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_W = 32,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              bp_en,
  input  logic [XLEN-1:0]   bp_addr,
  input  logic [XLEN-1:0]   core_pc,
  output logic              core_en,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_pc,
  output logic [CNT_W-1:0]  rsp_cycles,
  output logic [1:0]        rsp_status,
  output logic              halted
);
  state_t state, state_n;
  logic [CNT_W-1:0] cycle_cnt;
  logic [STEP_W-1:0] remaining;
  logic stepped, bp_hit, accept;
  logic [1:0] code, code_n;
  assign cmd_ready = state == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign halted = state == HALTED;
  // the stepped guard lets a STEP that starts on the breakpoint PC still execute one instruction
  assign bp_hit = bp_en && core_pc == bp_addr && stepped;
  assign core_en = state == RUN && !bp_hit && !rst;
  // next-state and pending stop code selection
  always_comb begin
    state_n = state;
    code_n = code;
    case (state)
      IDLE: if (accept) begin
        state_n = cmd_op == OP_STEP ? RUN : CAPTURE;
        code_n = cmd_op == OP_HALT ? ST_HALTED : ST_NOP_OK;
      end
      RUN: if (bp_hit || remaining == STEP_W'(1)) begin
        state_n = CAPTURE;
        code_n = bp_hit ? ST_BREAKPOINT : ST_STEP_DONE;
      end
      CAPTURE: state_n = REPORT;
      REPORT: if (rsp_ready) state_n = rsp_status == ST_HALTED ? HALTED : IDLE;
      HALTED: state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end
  // state register, step bookkeeping, retired-cycle counter and response snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      code <= ST_NOP_OK;
      cycle_cnt <= '0;
      remaining <= '0;
      stepped <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_pc <= '0;
      rsp_cycles <= '0;
      rsp_status <= ST_NOP_OK;
    end else begin
      state <= state_n;
      code <= code_n;
      if (accept && cmd_op == OP_STEP) begin
        remaining <= cmd_steps == '0 ? STEP_W'(1) : cmd_steps;
        stepped <= 1'b0;
      end
      if (core_en) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        remaining <= remaining - STEP_W'(1);
        stepped <= 1'b1;
      end
      if (state == CAPTURE) begin
        rsp_pc <= core_pc;
        rsp_cycles <= cycle_cnt;
        rsp_status <= code;
        rsp_valid <= 1'b1;
      end
      if (state == REPORT && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl against a PC+=4 core model
module tb_run_ctrl;
  import run_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, bp_en, core_en, rsp_valid, rsp_ready, halted;
  logic [1:0] cmd_op, rsp_status;
  logic [15:0] cmd_steps;
  logic [31:0] bp_addr, core_pc, rsp_pc, rsp_cycles;
  int n_chk = 0, n_fail = 0;
  int en, lat;
  logic [31:0] hold_pc, hold_cyc;
  logic [1:0] hold_st;
  always #5 clk = ~clk;
  always_ff @(posedge clk) core_pc <= rst ? 32'd0 : core_en ? core_pc + 32'd4 : core_pc;
  run_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_steps(cmd_steps), .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(core_pc),
    .core_en(core_en), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pc(rsp_pc),
    .rsp_cycles(rsp_cycles), .rsp_status(rsp_status), .halted(halted)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic [1:0] op, input logic [15:0] n, output int en_o, output int lat_o);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_steps = n;
    tick;
    cmd_valid = 1'b0;
    en_o = 0;
    lat_o = 0;
    while (!rsp_valid && lat_o < 300) begin
      en_o += int'(core_en);
      tick;
      lat_o++;
    end
    check("rsp_valid_timeout", rsp_valid, 1);
  endtask
  task automatic ack;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_core_en"}, core_en, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_pc"}, rsp_pc, 0);
    check({tag, "_rsp_cycles"}, rsp_cycles, 0);
    check({tag, "_rsp_status"}, rsp_status, 0);
    check({tag, "_halted"}, halted, 0);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    #1;
    check("core_en_in_rst", core_en, 0);
    tick;
    tick;
    rst = 1'b0;
    check_reset_outputs("reset");
  endtask
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_steps = '0;
    bp_en = 1'b0; bp_addr = '0; rsp_ready = 1'b0;
    tick;
    do_reset;
    cmd(OP_STEP, 16'd1, en, lat);
    check("step1_en", en, 1);
    check("step1_lat", lat, 2);
    check("step1_pc", rsp_pc, 4);
    check("step1_cycles", rsp_cycles, 1);
    check("step1_status", rsp_status, ST_STEP_DONE);
    ack;
    do_reset;
    bp_en = 1'b1;
    bp_addr = 32'd12;
    cmd(OP_STEP, 16'd5, en, lat);
    check("bp_en_cycles", en, 3);
    check("bp_pc", rsp_pc, 12);
    check("bp_cycles", rsp_cycles, 3);
    check("bp_status", rsp_status, ST_BREAKPOINT);
    ack;
    cmd(OP_STEP, 16'd1, en, lat);
    check("bp_leave_en", en, 1);
    check("bp_leave_pc", rsp_pc, 16);
    check("bp_leave_cycles", rsp_cycles, 4);
    check("bp_leave_status", rsp_status, ST_STEP_DONE);
    ack;
    bp_en = 1'b0;
    cmd(OP_STEP, 16'd0, en, lat);
    check("step0_en", en, 1);
    check("step0_pc", rsp_pc, 20);
    check("step0_cycles", rsp_cycles, 5);
    check("step0_status", rsp_status, ST_STEP_DONE);
    ack;
    cmd(OP_STEP, 16'd3, en, lat);
    check("step3_en", en, 3);
    check("step3_lat", lat, 4);
    check("step3_pc", rsp_pc, 32);
    check("step3_cycles", rsp_cycles, 8);
    ack;
    cmd(OP_NOP, 16'd7, en, lat);
    check("nop_en", en, 0);
    check("nop_lat", lat, 1);
    check("nop_status", rsp_status, ST_NOP_OK);
    check("nop_pc", rsp_pc, 32);
    check("nop_cycles", rsp_cycles, 8);
    hold_pc = rsp_pc;
    hold_cyc = rsp_cycles;
    hold_st = rsp_status;
    cmd_valid = 1'b1;
    cmd_op = OP_STEP;
    cmd_steps = 16'd2;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_pc", rsp_pc, hold_pc);
      check("bp_hold_cycles", rsp_cycles, hold_cyc);
      check("bp_hold_status", rsp_status, hold_st);
      check("bp_hold_cmd_ready", cmd_ready, 0);
      check("bp_hold_core_en", core_en, 0);
    end
    cmd_valid = 1'b0;
    ack;
    cmd(OP_HALT, 16'd0, en, lat);
    check("halt_lat", lat, 1);
    check("halt_status", rsp_status, ST_HALTED);
    check("halt_en", en, 0);
    check("halt_not_yet", halted, 0);
    ack;
    check("halted_flag", halted, 1);
    check("halted_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_op = OP_STEP;
    cmd_steps = 16'd4;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("halted_core_en", core_en, 0);
      check("halted_stay", halted, 1);
      check("halted_no_rsp", rsp_valid, 0);
    end
    cmd_valid = 1'b0;
    do_reset;
    cmd(OP_STEP, 16'd1, en, lat);
    check("post_halt_pc", rsp_pc, 4);
    check("post_halt_cycles", rsp_cycles, 1);
    ack;
    cmd_valid = 1'b1;
    cmd_op = OP_STEP;
    cmd_steps = 16'd100;
    tick;
    cmd_valid = 1'b0;
    en = 0;
    for (int i = 0; i < 39; i++) begin
      en += int'(core_en);
      tick;
    end
    check("mid_en_before", en, 39);
    check("mid_core_en_40", core_en, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_core_en", core_en, 0);
    tick;
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    cmd(OP_STEP, 16'd2, en, lat);
    check("after_mid_pc", rsp_pc, 8);
    check("after_mid_cycles", rsp_cycles, 2);
    ack;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
